rr_timeout_arbiter: RTL and testbench

//  N-port round-robin switch-allocator arbiter for the NoC router with per-port packet timeout.
//  One FSM grants at most one input port at a time. Each port has its own timeout limit, loaded

---
 rtl/rr_timeout_arbiter.sv | 101 ++++++++++
 tb/tb_rr_timeout_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_timeout_arbiter.sv
// Round-robin switch-allocator arbiter with a per-port grant timeout loaded from header flits.
// req/grant: a port asks by holding req; it owns the crossbar while grant is high, until it drops req or times out.
module rr_timeout_arbiter #(
    parameter int              N_PORTS   = 5,
    parameter int              LEN_W     = 12,
    parameter int              ID_W      = 3,
    parameter logic [ID_W-1:0] HEADER_ID = 3'b001
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_PORTS-1:0]         req,
    input  logic [ID_W*N_PORTS-1:0]    flit_id,
    input  logic [LEN_W*N_PORTS-1:0]   length,
    output logic [N_PORTS:0]           nextstate,
    output logic [N_PORTS:0]           state,
    output logic [N_PORTS-1:0]         grant,
    output logic [N_PORTS-1:0]         timeout
);

    localparam int ST_W  = N_PORTS + 1;
    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [ST_W-1:0] IDLE = ST_W'(1);

    logic [LEN_W-1:0]   cnt   [N_PORTS];
    logic [LEN_W-1:0]   limit [N_PORTS];
    logic [PTR_W-1:0]   lp;
    logic [N_PORTS-1:0] timesup;
    logic [N_PORTS-1:0] hold_vec;
    logic [N_PORTS-1:0] timeout_d;
    logic               state_valid;
    logic               hold;
    logic               search_hit;
    logic [PTR_W-1:0]   search_idx;
    logic [PTR_W-1:0]   probe_idx;

    assign grant       = state[N_PORTS:1];
    assign state_valid = (state != '0) && ((state & (state - ST_W'(1))) == '0);

    always_comb begin
        timesup   = '0;
        hold_vec  = '0;
        timeout_d = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            timesup[i]   = (cnt[i] >= limit[i]);
            hold_vec[i]  = state_valid && state[i+1] && req[i] && !timesup[i];
            timeout_d[i] = state_valid && state[i+1] && req[i] && timesup[i];
        end
        hold = |hold_vec;
    end

    // The current owner is visited last, so it only wins again when nobody else is asking.
    always_comb begin
        search_hit = 1'b0;
        search_idx = '0;
        probe_idx  = '0;
        for (int k = 1; k <= N_PORTS; k++) begin
            probe_idx = PTR_W'((int'(lp) + k) % N_PORTS);
            if (!search_hit && req[probe_idx]) begin
                search_hit = 1'b1;
                search_idx = probe_idx;
            end
        end
    end

    always_comb begin
        nextstate = IDLE;
        if (!state_valid)
            nextstate = IDLE;
        else if (hold)
            nextstate = state;
        else if (search_hit)
            nextstate = ST_W'(2) << search_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            lp      <= PTR_W'(N_PORTS - 1);
            timeout <= '0;
            for (int i = 0; i < N_PORTS; i++) begin
                cnt[i]   <= '0;
                limit[i] <= '0;
            end
        end else begin
            state   <= nextstate;
            timeout <= timeout_d;
            if (state_valid && !hold && search_hit)
                lp <= search_idx;
            for (int i = 0; i < N_PORTS; i++) begin
                // A new header takes effect next cycle; timesup this cycle still sees the old limit.
                if (flit_id[i*ID_W +: ID_W] == HEADER_ID)
                    limit[i] <= length[i*LEN_W +: LEN_W];
                if (hold_vec[i])
                    cnt[i] <= (cnt[i] == {LEN_W{1'b1}}) ? cnt[i] : cnt[i] + LEN_W'(1);
                else
                    cnt[i] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rr_timeout_arbiter.sv
// Bench for rr_timeout_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against an owner/elapsed-time model of the arbitration rules.
module tb_rr_timeout_arbiter;

    localparam int N  = 5;
    localparam int LW = 12;
    localparam int IW = 3;
    localparam logic [IW-1:0] HDR = 3'b001;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [IW*N-1:0] flit_id;
    logic [LW*N-1:0] length;
    logic [N:0]      nextstate;
    logic [N:0]      state;
    logic [N-1:0]    grant;
    logic [N-1:0]    timeout;

    int n_checks = 0;
    int n_errors = 0;

    rr_timeout_arbiter #(.N_PORTS(N), .LEN_W(LW), .ID_W(IW), .HEADER_ID(HDR)) dut (
        .clk(clk), .rst(rst), .req(req), .flit_id(flit_id), .length(length),
        .nextstate(nextstate), .state(state), .grant(grant), .timeout(timeout)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_hdr(input int p, input int len);
        flit_id[p*IW +: IW] = HDR;
        length[p*LW +: LW]  = LW'(len);
    endtask

    task automatic clear_hdr();
        flit_id = '0;
        length  = '0;
    endtask

    // behavioural model: who owns the crossbar, how long it has held it, limits, last grant
    int          m_owner;
    int          m_held;
    int          m_limit [N];
    int          m_lp;
    logic [N-1:0] m_timeout;
    bit          m_live = 0;
    logic [N:0]  exp_q[$];

    function automatic logic [N:0] enc(input int owner);
        logic [N:0] v;
        v = '0;
        if (owner < 0) v[0] = 1'b1;
        else v[owner+1] = 1'b1;
        return v;
    endfunction

    always @(negedge clk) begin
        int  nxt;
        bit  tsup;
        bit  keep;
        logic [N:0] cur;
        if (m_live) begin
            cur = enc(m_owner);
            exp_q.push_back(cur);
            check("model_state", 32'(state), 32'(exp_q.pop_front()));
            check("model_grant", 32'(grant), 32'(cur[N:1]));
            check("model_timeout", 32'(timeout), 32'(m_timeout));
        end
        tsup = (m_owner >= 0) && (m_held >= m_limit[m_owner >= 0 ? m_owner : 0]);
        keep = (m_owner >= 0) && req[m_owner >= 0 ? m_owner : 0] && !tsup;
        nxt = -1;
        if (keep) nxt = m_owner;
        else begin
            for (int k = 1; k <= N; k++) begin
                int p;
                p = (m_lp + k) % N;
                if (nxt < 0 && req[p]) nxt = p;
            end
        end
        if (m_live) check("model_nextstate", 32'(nextstate), 32'(enc(nxt)));
        if (rst) begin
            m_owner = -1; m_held = 0; m_lp = N - 1; m_timeout = '0;
            for (int i = 0; i < N; i++) m_limit[i] = 0;
            m_live = 1;
        end else if (m_live) begin
            m_timeout = '0;
            if (m_owner >= 0 && req[m_owner] && tsup) m_timeout[m_owner] = 1'b1;
            m_held = keep ? ((m_held + 1 > 4095) ? 4095 : m_held + 1) : 0;
            for (int i = 0; i < N; i++)
                if (flit_id[i*IW +: IW] == HDR) m_limit[i] = int'(length[i*LW +: LW]);
            if (nxt >= 0) m_lp = nxt;
            m_owner = nxt;
        end
    end

    // directed scenarios, then random traffic
    initial begin
        logic [N-1:0] seq [6];
        rst = 1'b1; req = '0; clear_hdr();
        repeat (3) step();
        check("rst_state", 32'(state), 32'h01);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        check("rst_nextstate", 32'(nextstate), 32'h01);
        rst = 1'b0;
        step();
        check("idle_state", 32'(state), 32'h01);

        // port 0, limit 3: four grant cycles, then a timeout pulse and re-acquisition
        req = 5'b00001; set_hdr(0, 3);
        for (int c = 0; c < 4; c++) begin
            step();
            check("p0_hold_grant", 32'(grant), 32'h01);
            check("p0_hold_timeout", 32'(timeout), 32'h0);
        end
        step();
        check("p0_regrant", 32'(grant), 32'h01);
        check("p0_timeout_pulse", 32'(timeout), 32'h01);
        step();
        check("p0_timeout_once", 32'(timeout), 32'h0);

        // zero all limits
        req = '0;
        for (int i = 0; i < N; i++) set_hdr(i, 0);
        step(); step();
        clear_hdr();
        check("zero_idle", 32'(state), 32'h01);

        // single-cycle round robin over ports 1, 2, 4
        seq[0] = 5'b00010; seq[1] = 5'b00100; seq[2] = 5'b10000;
        seq[3] = 5'b00010; seq[4] = 5'b00100; seq[5] = 5'b10000;
        req = 5'b10110;
        for (int c = 0; c < 6; c++) begin
            step();
            check("rr_grant", 32'(grant), 32'(seq[c]));
            if (c > 0) check("rr_timeout", 32'(timeout), 32'(seq[c-1]));
        end

        // port 2 drops req while port 0 waits
        req = 5'b00100; set_hdr(2, 100);
        step();
        check("p2_grant", 32'(grant), 32'h04);
        clear_hdr();
        step();
        check("p2_hold", 32'(grant), 32'h04);
        req = 5'b00001;
        step();
        check("p2_release_grant", 32'(grant), 32'h01);
        check("p2_release_timeout", 32'(timeout), 32'h0);

        // port 1 limit 10, reloaded to 2 at count 6
        req = 5'b00010; set_hdr(1, 10);
        step();
        check("p1_grant", 32'(grant), 32'h02);
        clear_hdr(); req = 5'b00011;
        for (int c = 0; c < 6; c++) begin
            step();
            check("p1_hold", 32'(grant), 32'h02);
        end
        set_hdr(1, 2);
        step();
        check("p1_reload_hold", 32'(grant), 32'h02);
        check("p1_reload_timeout", 32'(timeout), 32'h0);
        clear_hdr();
        step();
        check("p1_expire_grant", 32'(grant), 32'h01);
        check("p1_expire_timeout", 32'(timeout), 32'h02);

        // reset during a port 3 grant
        req = 5'b01000; set_hdr(3, 50);
        step();
        check("p3_grant", 32'(grant), 32'h08);
        clear_hdr();
        step();
        rst = 1'b1;
        step();
        check("p3_rst_state", 32'(state), 32'h01);
        check("p3_rst_timeout", 32'(timeout), 32'h0);
        rst = 1'b0;
        step();
        check("p3_after_rst", 32'(grant), 32'h08);
        step();
        check("p3_cleared_limit", 32'(timeout), 32'h08);

        // random traffic, checked by the model
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 31));
            for (int i = 0; i < N; i++) begin
                flit_id[i*IW +: IW] = ($urandom_range(0, 3) == 0) ? HDR : IW'($urandom_range(0, 7));
                length[i*LW +: LW]  = LW'($urandom_range(0, 6));
            end
            step();
        end
        rst = 1'b0; req = '0; clear_hdr();
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
